// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_arbiter
// Description : Round-robin arbiter with registered one-hot/indexed grant,
//               a bounded hold time and a turnaround cycle between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    w_ptr_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [HOLD_W-1:0]   w_hold_cnt_nxt;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        w_gnt_nxt;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic [IDX_W-1:0]    w_gnt_idx_nxt;
    logic                r_gnt_valid;
    logic                w_gnt_valid_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic                w_found;
    logic [IDX_W-1:0]    w_winner;
    logic [IDX_W-1:0]    w_cand;

    // Scan starts at the pointer and wraps, so the lowest offset from ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 0; i < N; i++) begin
            w_cand = r_ptr + IDX_W'(i);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_idx_nxt   = r_gnt_idx;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                if (w_found) begin
                    w_gnt_nxt       = N'(1) << w_winner;
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = '0;
                    w_state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (!req[r_gnt_idx] || (r_hold_cnt == c_HOLD_LAST)) begin
                    // Owner released or ran out of hold time; either way the
                    // next owner search starts just past it.
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_hold_cnt_nxt  = '0;
                    w_ptr_nxt       = r_gnt_idx + IDX_W'(1);
                    w_timeout_nxt   = req[r_gnt_idx];
                    w_state_nxt     = IDLE;
                end else begin
                    w_hold_cnt_nxt  = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_idx   <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_idx   <= w_gnt_idx_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_arbiter
// Description : Self-checking bench for rr_grant_arbiter against a
//               cycle-level behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    int n_vec;
    int n_err;

    // Model state: current owner (-1 when none), search start, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    int grant_seq;
    int timeouts_seen;
    logic [N-1:0] cur_req;

    rr_grant_arbiter #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r);
        m_timeout = 1'b0;
        if (m_owner < 0) begin
            for (int j = 0; j < N; j++) begin
                int c;
                c = (m_ptr + j) % N;
                if (r[c]) begin
                    m_owner = c;
                    m_hold  = 0;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (m_hold == MAX_HOLD - 1) begin
            m_ptr     = (m_owner + 1) % N;
            m_owner   = -1;
            m_timeout = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        if (m_owner >= 0) check("gnt_idx", 32'(gnt_idx), 32'(m_owner));
        check("timeout", 32'(timeout), 32'(m_timeout));
        check("onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (timeout) timeouts_seen++;
    endtask

    // Apply one request vector across one active edge and check afterwards.
    task automatic cyc(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        timeouts_seen = 0;
        rst_n         = 1'b1;
        req           = '0;
        model_reset();
        #2;
        do_reset();
        compare_all();

        // Reset asserted mid-grant takes effect without a clock edge.
        cyc(8'h10);
        cyc(8'h10);
        cyc(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(8'h01);
        check("post_rst_gnt", 32'(gnt), 32'h01);
        cyc(8'h00);
        cyc(8'h00);

        // Single requester held for five cycles, then dropped.
        for (int i = 0; i < 5; i++) cyc(8'h20);
        check("single_idx", 32'(gnt_idx), 32'd5);
        cyc(8'h00);
        check("single_drop", 32'(gnt), 32'h0);
        cyc(8'h00);

        // Round robin: every owner releases three cycles into its grant.
        do_reset();
        grant_seq = 0;
        for (int c = 0; c < 60 && grant_seq < N + 1; c++) begin
            cur_req = 8'hFF;
            if (m_owner >= 0 && m_hold == 2) cur_req[m_owner] = 1'b0;
            cyc(cur_req);
            if (gnt_valid && m_hold == 0 && m_owner >= 0) begin
                check("rr_order", 32'(gnt_idx), 32'(grant_seq % N));
                grant_seq++;
            end
        end
        check("rr_count", 32'(grant_seq), 32'(N + 1));

        // Wraparound from ptr=6 to requesters 0 and 2.
        do_reset();
        cyc(8'h20);
        cyc(8'h20);
        cyc(8'h00);
        cyc(8'h05);
        check("wrap_first", 32'(gnt_idx), 32'd0);
        cyc(8'h05);
        cyc(8'h05);
        cyc(8'h04);
        cyc(8'h04);
        check("wrap_second", 32'(gnt_idx), 32'd2);
        cyc(8'h00);
        cyc(8'h00);

        // Timeout: a lone requester held for 40 cycles.
        do_reset();
        timeouts_seen = 0;
        for (int i = 0; i < 40; i++) cyc(8'h08);
        check("timeout_count", 32'(timeouts_seen), 32'd2);
        cyc(8'h00);
        cyc(8'h00);

        // Owner 2 releases while 1 and 4 rise: ptr=3 picks 4.
        do_reset();
        cyc(8'h04);
        cyc(8'h04);
        cyc(8'h04);
        cyc(8'h12);
        cyc(8'h12);
        check("contention_idx", 32'(gnt_idx), 32'd4);
        cyc(8'h00);
        cyc(8'h00);

        // Randomized traffic, with the owner's bit usually kept to reach timeouts.
        do_reset();
        cur_req = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                logic [N-1:0] nv;
                nv = N'($urandom);
                if ($urandom_range(0, 9) == 0) nv = '0;
                if (m_owner >= 0 && $urandom_range(0, 3) != 0) nv[m_owner] = 1'b1;
                cur_req = nv;
            end
            cyc(cur_req);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
